// File: rtl/if_fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch controller:
// FSM state encoding, PC step and the NOP encoding.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, holds the fetched
// PC/instruction pair until IF/ID accepts it. Optional feature macro: IF_MISALIGN_CHK_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        if_misalign_o
`endif
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         kill_reg, kill_next;
  logic         valid_reg, valid_next;
  logic [31:0]  if_pc_reg, if_pc_next;
  logic [31:0]  inst_reg, inst_next;
  logic         misalign_reg, misalign_next;
  logic [31:0]  redir_pc;
  logic         redir_misalign;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_pc       = redirect_pc_i;
  assign redir_misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign if_misalign_o  = misalign_reg;
`else
  // Without the check, targets are word-aligned by construction.
  logic redir_lsb_unused;
  logic misalign_unused;
  assign redir_pc         = {redirect_pc_i[31:2], 2'b00};
  assign redir_misalign   = 1'b0;
  assign redir_lsb_unused = ^redirect_pc_i[1:0];
  assign misalign_unused  = misalign_reg;
`endif

  assign imem_req_o  = (state_reg == ST_REQ);
  assign imem_addr_o = pc_reg;
  assign if_valid_o  = valid_reg;
  assign if_pc_o     = if_pc_reg;
  assign if_inst_o   = inst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_PC;
      kill_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      if_pc_reg    <= 32'h0;
      inst_reg     <= 32'h0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      kill_reg     <= kill_next;
      valid_reg    <= valid_next;
      if_pc_reg    <= if_pc_next;
      inst_reg     <= inst_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    kill_next     = kill_reg;
    valid_next    = valid_reg;
    if_pc_next    = if_pc_reg;
    inst_next     = inst_reg;
    misalign_next = misalign_reg;

    // A killed response landing outside WAIT still retires the kill.
    if (imem_rvalid_i && kill_reg && (state_reg != ST_WAIT)) kill_next = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        state_next = ST_REQ;
        if (redirect_i) pc_next = redir_pc;
      end
      ST_REQ: begin
        if (redirect_i) begin
          pc_next = redir_pc;
          if (imem_gnt_i) begin
            kill_next  = 1'b1;
            state_next = ST_WAIT;
          end
        end else if (imem_gnt_i) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_next = redir_pc;
          if (imem_rvalid_i) begin
            kill_next  = 1'b0;
            state_next = ST_REQ;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            state_next = ST_REQ;
          end else begin
            valid_next = 1'b1;
            if_pc_next = pc_reg;
            inst_next  = imem_rdata_i;
            state_next = ST_HOLD;
          end
        end
      end
      default: begin // ST_HOLD
        if (redirect_i) begin
          pc_next       = redir_pc;
          valid_next    = 1'b0;
          misalign_next = 1'b0;
          state_next    = ST_REQ;
        end else if (!stall_i) begin
          pc_next       = pc_reg + PC_INC;
          valid_next    = 1'b0;
          misalign_next = 1'b0;
          state_next    = ST_REQ;
        end
      end
    endcase

    // Misaligned target: present a NOP instead of fetching; any request in flight is killed.
    if (redir_misalign) begin
      state_next    = ST_HOLD;
      pc_next       = redirect_pc_i;
      valid_next    = 1'b1;
      misalign_next = 1'b1;
      if_pc_next    = redirect_pc_i;
      inst_next     = NOP_INST;
      kill_next     = ((state_reg == ST_REQ) && imem_gnt_i) ||
                      (((state_reg == ST_WAIT) || kill_reg) && !imem_rvalid_i);
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 stall_i  input  1  SHALL mean the downstream IF/ID register cannot accept the held instruction.
REQ-005 redirect_i  input  1  SHALL mean a branch/jump redirect request.
REQ-006 redirect_pc_i  input  32  SHALL be the redirect target, sampled when redirect_i=1.
REQ-007 imem_req_o  output  1  SHALL be the instruction memory request.
REQ-008 imem_addr_o  output  32  SHALL be the request address, equal to the current PC.
REQ-009 imem_gnt_i  input  1  SHALL be the request grant; a handshake completes when imem_req_o=1 and imem_gnt_i=1.
REQ-010 imem_rvalid_i  input  1, imem_rdata_i  input  32  SHALL carry the read response, one per granted request.
REQ-011 if_valid_o  output  1, if_pc_o  output  32, if_inst_o  output  32  SHALL present the fetched PC/instruction pair to the IF/ID register.
REQ-012 if_misalign_o  output  1  SHALL exist only when IF_MISALIGN_CHK_EN is defined.

Function
REQ-013 FSM states: BOOT, REQ, WAIT, HOLD; at most one request outstanding.
REQ-014 BOOT: imem_req_o=0; next state SHALL be REQ.
REQ-015 REQ: imem_req_o=1, imem_addr_o=pc; on imem_gnt_i=1, next state SHALL be WAIT; otherwise remain in REQ.
REQ-016 WAIT: imem_req_o=0; on imem_rvalid_i=1 with no kill pending, register if_pc_o=pc, if_inst_o=imem_rdata_i, set if_valid_o=1, and move to HOLD one cycle after rvalid.
REQ-017 HOLD with stall_i=0: pair consumed; pc <= pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), if_valid_o <= 0, next state REQ.
REQ-018 HOLD with stall_i=1: all outputs SHALL hold unchanged.
REQ-019 Redirect has priority over stall and grant; pc <= redirect_pc_i in every state.
REQ-020 Redirect in REQ: next state REQ with the new address; a same-cycle grant SHALL be treated as a granted request that must be killed.
REQ-021 Redirect in WAIT, or in REQ with a same-cycle grant: set kill; the next response SHALL be discarded with if_valid_o left 0, then the FSM moves to REQ.
REQ-022 Redirect coincident with rvalid in WAIT: the response SHALL be discarded; next state REQ.
REQ-023 Redirect in HOLD: if_valid_o <= 0 next cycle; next state REQ.
REQ-024 Redirect in BOOT: pc <= redirect_pc_i; next state REQ.
REQ-025 Responses with imem_rvalid_i=1 outside WAIT SHALL be ignored.

Reset
REQ-026 On rst_n=0: state=BOOT, pc=RESET_PC, kill=0, imem_req_o=0, if_valid_o=0, if_pc_o=32'h0, if_inst_o=32'h0, if_misalign_o=0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding request without waiting for rvalid.

Configuration
REQ-028 Macro IF_MISALIGN_CHK_EN defined: a redirect_pc_i with bits[1:0]!=0 SHALL suppress the fetch, drive if_valid_o=1, if_misalign_o=1, if_pc_o=redirect target, if_inst_o=32'h0000_0013 (NOP), and enter HOLD; if_misalign_o clears when the pair is consumed.
REQ-029 Macro IF_MISALIGN_CHK_EN undefined: the port is absent; redirect_pc_i[1:0] SHALL be forced to 2'b00.

Structure
REQ-030 The shared core package SHALL hold the FSM state encoding, the PC increment constant (4), and the NOP encoding 32'h0000_0013.
REQ-031 The block SHALL be a single module with no sub-modules; the PC register and FSM SHALL be inline.

Verification
REQ-032 Reset release, gnt and rvalid tied high: addresses 0x0, 0x4, 0x8 issued; if_pc_o values 0x0, 0x4, 0x8 each with if_valid_o=1.
REQ-033 stall_i=1 for 5 cycles in HOLD at pc 0x10: if_pc_o/if_inst_o stable, no request issued; after release, next request at 0x14.
REQ-034 Redirect to 0x200 in WAIT: response for the old PC discarded (if_valid_o stays 0); next request at 0x200.
REQ-035 imem_gnt_i held low for 4 cycles: imem_req_o and imem_addr_o stable; redirect to 0x80 during the wait changes the address to 0x80 next cycle.
REQ-036 PC 32'hFFFF_FFFC consumed: next request at 32'h0000_0000.
REQ-037 With IF_MISALIGN_CHK_EN defined, redirect to 0x102: no imem request; if_misalign_o=1, if_pc_o=0x102, if_inst_o=0x13.
